// File: rtl/keypad_pkg.sv
`default_nettype none
// ---- keypad_pkg : shared encodings for the keypad entry path ---- rev 1.0 ----
package keypad_pkg;

  localparam int KEY_W   = 10;
  localparam int DIGIT_W = 4;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE     = 2'd1;
  localparam logic [1:0] ST_CAPTURE      = 2'd2;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

  localparam logic [DIGIT_W-1:0] MAX_SEC_TENS = 4'd5;

  typedef enum logic [1:0] {
    S_IDLE         = ST_IDLE,
    S_DEBOUNCE     = ST_DEBOUNCE,
    S_CAPTURE      = ST_CAPTURE,
    S_WAIT_RELEASE = ST_WAIT_RELEASE
  } state_t;

  function automatic logic [1:0] sat_inc2(input logic [1:0] c);
    return (c == 2'd3) ? c : c + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_shift_reg3.sv
`default_nettype none
// ---- bcd_shift_reg3 : 3-digit M:SS entry register, clear beats shift ---- rev 1.0 ----
module bcd_shift_reg3
  import keypad_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_shift,
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_min_ones,
  output logic [DIGIT_W-1:0] o_sec_tens,
  output logic [DIGIT_W-1:0] o_sec_ones,
  output logic [1:0]         o_count
);

  logic [DIGIT_W-1:0] r_min_ones;
  logic [DIGIT_W-1:0] r_sec_tens;
  logic [DIGIT_W-1:0] r_sec_ones;
  logic [1:0]         r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_min_ones <= '0;
      r_sec_tens <= '0;
      r_sec_ones <= '0;
      r_count    <= '0;
    end else if (i_shift) begin
      // oldest digit falls off the top once three are held
      r_min_ones <= r_sec_tens;
      r_sec_tens <= r_sec_ones;
      r_sec_ones <= i_digit;
      r_count    <= sat_inc2(r_count);
    end
  end

  assign o_min_ones = r_min_ones;
  assign o_sec_tens = r_sec_tens;
  assign o_sec_ones = r_sec_ones;
  assign o_count    = r_count;

endmodule
`default_nettype wire

// File: rtl/keypad_entry_controller.sv
`default_nettype none
// ---- keypad_entry_controller : debounce, encoder enable and M:SS entry ---- rev 1.0 ----
module keypad_entry_controller
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [KEY_W-1:0]   keypad,
  input  logic               entry_en,
  input  logic               clear_entry,
  input  logic               start,
  input  logic [DIGIT_W-1:0] D,
  output logic               enablen,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [1:0]         digit_count,
  output logic               entry_valid,
  output logic               load_pulse
);

  localparam logic [CNT_W-1:0] c_DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  state_t             r_state;
  state_t             w_next_state;
  logic [KEY_W-1:0]   r_key_snap;
  logic [KEY_W-1:0]   w_key_snap_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_load_pulse;
  logic               w_key_any;
  logic               w_capture;

  assign w_key_any = |keypad;
  assign w_capture = (r_state == S_CAPTURE);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_key_snap   <= '0;
      r_cnt        <= '0;
      r_load_pulse <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_key_snap   <= w_key_snap_nxt;
      r_cnt        <= w_cnt_nxt;
      r_load_pulse <= start && entry_valid;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_key_snap_nxt = r_key_snap;
    w_cnt_nxt      = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (entry_en && w_key_any) begin
          w_key_snap_nxt = keypad;
          w_cnt_nxt      = '0;
          w_next_state   = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (!entry_en || !w_key_any) begin
          w_cnt_nxt    = '0;
          w_next_state = S_IDLE;
        end else if (keypad != r_key_snap) begin
          // any change in the pressed pattern restarts the stability window
          w_key_snap_nxt = keypad;
          w_cnt_nxt      = '0;
        end else if (r_cnt == c_DB_LAST) begin
          w_next_state = S_CAPTURE;
        end else if (r_cnt != c_CNT_MAX) begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      S_CAPTURE: begin
        w_next_state = S_WAIT_RELEASE;
      end
      S_WAIT_RELEASE: begin
        if (!w_key_any) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  bcd_shift_reg3 u_digits (
    .clk        (clock),
    .rst        (reset),
    .i_clear    (clear_entry || r_load_pulse),
    .i_shift    (w_capture),
    .i_digit    (D),
    .o_min_ones (min_ones),
    .o_sec_tens (sec_tens),
    .o_sec_ones (sec_ones),
    .o_count    (digit_count)
  );

  assign enablen     = !w_capture;
  assign load_pulse  = r_load_pulse;
  assign entry_valid = (digit_count != 2'd0) && (sec_tens <= MAX_SEC_TENS);

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry_controller.sv
`default_nettype none
// ---- tb_keypad_entry_controller : directed, table-driven check of keypad entry ---- rev 1.0 ----
module tb_keypad_entry_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] keypad;
  logic       entry_en;
  logic       clear_entry;
  logic       start;
  logic [3:0] D;
  logic       enablen;
  logic [3:0] sec_ones, sec_tens, min_ones;
  logic [1:0] digit_count;
  logic       entry_valid;
  logic       load_pulse;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  keypad_entry_controller dut (
    .clock       (clock),
    .reset       (reset),
    .keypad      (keypad),
    .entry_en    (entry_en),
    .clear_entry (clear_entry),
    .start       (start),
    .D           (D),
    .enablen     (enablen),
    .sec_ones    (sec_ones),
    .sec_tens    (sec_tens),
    .min_ones    (min_ones),
    .digit_count (digit_count),
    .entry_valid (entry_valid),
    .load_pulse  (load_pulse)
  );

  // priority encoder model: highest pressed key wins
  function automatic logic [3:0] enc(input logic [9:0] k);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 10; i++) if (k[i]) r = 4'(i);
    return r;
  endfunction

  always_comb D = enc(keypad);

  typedef struct {
    bit         clr_before;
    int         key;
    int         hold;
    bit         en;
    int         exp_pulses;
    logic [3:0] m, t, o;
    logic [1:0] c;
    bit         ev;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic pulse_clear();
    clear_entry = 1'b1;
    step();
    clear_entry = 1'b0;
  endtask

  task automatic press(input int key, input int hold, input bit en,
                       output int pulses, output int first_at);
    entry_en    = en;
    keypad      = '0;
    keypad[key] = 1'b1;
    pulses      = 0;
    first_at    = 0;
    for (int i = 1; i <= hold; i++) begin
      step();
      if (!enablen) begin
        pulses++;
        if (first_at == 0) first_at = i;
      end
    end
    keypad = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (!enablen) pulses++;
    end
    entry_en = 1'b1;
  endtask

  task automatic check_digits(input string tag, input int m, input int t, input int o, input int c);
    check({tag, ".min_ones"}, min_ones, m);
    check({tag, ".sec_tens"}, sec_tens, t);
    check({tag, ".sec_ones"}, sec_ones, o);
    check({tag, ".count"}, digit_count, c);
  endtask

  initial begin
    int p, f, lows;
    bit found;

    tbl[0] = '{1'b0, 5, 20, 1'b1, 1, 4'd0, 4'd0, 4'd5, 2'd1, 1'b1};
    tbl[1] = '{1'b1, 1,  8, 1'b1, 1, 4'd0, 4'd0, 4'd1, 2'd1, 1'b1};
    tbl[2] = '{1'b0, 3,  6, 1'b1, 1, 4'd0, 4'd1, 4'd3, 2'd2, 1'b1};
    tbl[3] = '{1'b0, 0,  6, 1'b1, 1, 4'd1, 4'd3, 4'd0, 2'd3, 1'b1};
    tbl[4] = '{1'b0, 7,  7, 1'b1, 1, 4'd3, 4'd0, 4'd7, 2'd3, 1'b1};
    tbl[5] = '{1'b0, 9, 10, 1'b0, 0, 4'd3, 4'd0, 4'd7, 2'd3, 1'b1};

    reset = 1'b1; keypad = '0; entry_en = 1'b1; clear_entry = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0;
    step();
    check("rst.enablen", enablen, 1);
    check("rst.load_pulse", load_pulse, 0);
    check("rst.entry_valid", entry_valid, 0);
    check_digits("rst", 0, 0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      if (tbl[r].clr_before) pulse_clear();
      press(tbl[r].key, tbl[r].hold, tbl[r].en, p, f);
      check($sformatf("row%0d.pulses", r), p, tbl[r].exp_pulses);
      if (tbl[r].exp_pulses > 0) check($sformatf("row%0d.latency", r), f, 5);
      check_digits($sformatf("row%0d", r), tbl[r].m, tbl[r].t, tbl[r].o, tbl[r].c);
      check($sformatf("row%0d.entry_valid", r), entry_valid, tbl[r].ev);
    end

    // reset while debouncing key 3
    keypad = 10'b0000001000;
    step(); step();
    reset = 1'b1;
    step();
    reset  = 1'b0;
    keypad = '0;
    check("rstdb.enablen", enablen, 1);
    check("rstdb.load_pulse", load_pulse, 0);
    check_digits("rstdb", 0, 0, 0, 0);
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!enablen) lows++;
    end
    check("rstdb.no_capture", lows, 0);
    check("rstdb.count_after", digit_count, 0);

    // bouncing key 1
    lows = 0;
    keypad = 10'b0000000010; step(); if (!enablen) lows++;
    keypad = '0;             step(); if (!enablen) lows++;
    keypad = 10'b0000000010; step(); if (!enablen) lows++;
    keypad = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (!enablen) lows++;
    end
    check("bounce.no_capture", lows, 0);
    check("bounce.count", digit_count, 0);
    press(2, 8, 1'b1, p, f);
    check("bounce.stable_pulses", p, 1);
    check_digits("bounce.stable", 0, 0, 2, 1);

    // 2:45 then start
    pulse_clear();
    press(2, 6, 1'b1, p, f);
    press(4, 6, 1'b1, p, f);
    press(5, 6, 1'b1, p, f);
    check_digits("e245", 2, 4, 5, 3);
    check("e245.entry_valid", entry_valid, 1);
    check("e245.idle_load", load_pulse, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("e245.load_pulse", load_pulse, 1);
    check_digits("e245.at_pulse", 2, 4, 5, 3);
    step();
    check("e245.pulse_end", load_pulse, 0);
    check_digits("e245.after", 0, 0, 0, 0);

    // 0:75 is not a valid entry
    press(0, 6, 1'b1, p, f);
    press(7, 6, 1'b1, p, f);
    press(5, 6, 1'b1, p, f);
    check_digits("e075", 0, 7, 5, 3);
    check("e075.entry_valid", entry_valid, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("e075.load_pulse", load_pulse, 0);
    step();
    check("e075.load_pulse2", load_pulse, 0);
    check_digits("e075.kept", 0, 7, 5, 3);

    // clear coinciding with the capture of key 4
    keypad = 10'b0000010000;
    found  = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (!enablen) found = 1'b1;
    end
    check("clrcap.capture_seen", found, 1);
    clear_entry = 1'b1;
    step();
    clear_entry = 1'b0;
    check_digits("clrcap", 0, 0, 0, 0);
    keypad = '0;
    step(); step();
    check("clrcap.entry_valid", entry_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
